// File: rtl/maze_pkg.sv
// Shared maze cell encodings, tile colours and store FSM states.
// Imported by the grid store and its strobe synchronizer.
package maze_pkg;

  localparam logic [1:0] UNEXPLORED = 2'd0;
  localparam logic [1:0] VISITED    = 2'd1;
  localparam logic [1:0] WALL       = 2'd2;
  localparam logic [1:0] TREASURE   = 2'd3;

  localparam logic [7:0] COLOR_UNEXPLORED = 8'h00;
  localparam logic [7:0] COLOR_VISITED    = 8'h1C;
  localparam logic [7:0] COLOR_WALL       = 8'hE0;
  localparam logic [7:0] COLOR_TREASURE   = 8'hFC;
  localparam logic [7:0] GRID_LINE_COLOR  = 8'h92;
  localparam logic [7:0] COLOR_BLANK      = 8'h00;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic [7:0] value_color(
    input logic [1:0] v
  );
    logic [7:0] c;
    c = COLOR_UNEXPLORED;
    unique case (v)
      UNEXPLORED: c = COLOR_UNEXPLORED;
      VISITED:    c = COLOR_VISITED;
      WALL:       c = COLOR_WALL;
      TREASURE:   c = COLOR_TREASURE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/enable_sync.sv
// 3-flop synchronizer for the GPIO write strobe with a registered
// rising-edge pulse; coordinate/value bus follows s1/s2 in lockstep.
module enable_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_in,
  input  logic [3:0] x_in,
  input  logic [3:0] y_in,
  input  logic [1:0] val_in,
  output logic       pulse,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic [1:0] val_out
);

  logic [2:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;
  logic [9:0] bus1_q, bus1_d;
  logic [9:0] bus2_q, bus2_d;

  always_comb begin
    sync_d  = {sync_q[1:0], en_in};
    pulse_d = sync_q[1] & ~sync_q[2];
    bus1_d  = {x_in, y_in, val_in};
    bus2_d  = bus1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
      bus1_q  <= '0;
      bus2_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
      bus1_q  <= bus1_d;
      bus2_q  <= bus2_d;
    end
  end

  assign pulse   = pulse_q;
  assign x_out   = bus2_q[9:6];
  assign y_out   = bus2_q[5:2];
  assign val_out = bus2_q[1:0];

endmodule

// File: rtl/grid_map_store.sv
// Maze cell store: clear sweep, one write per GPIO strobe, and a
// 2-stage pixel lookup that renders the grid as coloured tiles.
module grid_map_store
  import maze_pkg::*;
#(
  parameter int GRID_COLS = 5,
  parameter int GRID_ROWS = 4,
  parameter int CELL_LOG2 = 5
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] X_COORD,
  input  logic [3:0] Y_COORD,
  input  logic [1:0] VALUE,
  input  logic       ENABLE_IN,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  output logic [7:0] PIXEL_COLOR,
  output logic       READY,
  output logic       OOR_FLAG
);

  localparam int NCELLS = GRID_COLS * GRID_ROWS;
  localparam int AW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  logic       wr_pulse;
  logic [3:0] wr_x, wr_y;
  logic [1:0] wr_val;

  enable_sync u_sync (
    .clk     (CLOCK_50),
    .rst     (RESET),
    .en_in   (ENABLE_IN),
    .x_in    (X_COORD),
    .y_in    (Y_COORD),
    .val_in  (VALUE),
    .pulse   (wr_pulse),
    .x_out   (wr_x),
    .y_out   (wr_y),
    .val_out (wr_val)
  );

  state_e     state_q, state_d;
  logic [7:0] clr_q, clr_d;
  logic       oor_q, oor_d;

  logic       we;
  logic [7:0] waddr;
  logic [1:0] wdata;
  logic [7:0] strobe_addr;
  logic       strobe_ok;

  always_comb begin
    strobe_addr = {4'b0, wr_y} * 8'(GRID_COLS) + {4'b0, wr_x};
    strobe_ok   = ({4'b0, wr_x} < 8'(GRID_COLS)) &&
                  ({4'b0, wr_y} < 8'(GRID_ROWS));
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    oor_d   = oor_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = UNEXPLORED;
    unique case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        if (clr_q == 8'(NCELLS - 1)) state_d = ST_RUN;
        else clr_d = clr_q + 8'd1;
      end
      ST_RUN: begin
        if (wr_pulse) begin
          if (strobe_ok) begin
            we    = 1'b1;
            waddr = strobe_addr;
            wdata = wr_val;
          end else begin
            oor_d = 1'b1;
          end
        end
      end
    endcase
  end

  logic [1:0] cells_q [NCELLS];
  logic [1:0] cells_d [NCELLS];

  always_comb begin
    cells_d = cells_q;
    if (we) cells_d[AW'(waddr)] = wdata;
  end

  // Array is not reset: the CLEAR sweep zeroes it instead.
  always_ff @(posedge CLOCK_50) begin
    cells_q <= cells_d;
  end

  logic [9:0] col_full, row_full;
  logic [7:0] col_q, col_d, row_q, row_d;
  logic       in_grid_q, in_grid_d;
  logic       line_q, line_d;
  logic [7:0] pix_q, pix_d;
  logic [7:0] raddr;
  logic [1:0] rdata;

  always_comb begin
    col_full  = PIXEL_X >> CELL_LOG2;
    row_full  = PIXEL_Y >> CELL_LOG2;
    in_grid_d = (col_full < 10'(GRID_COLS)) &&
                (row_full < 10'(GRID_ROWS));
    line_d    = (PIXEL_X[CELL_LOG2-1:0] == '0) ||
                (PIXEL_Y[CELL_LOG2-1:0] == '0);
    col_d     = col_full[7:0];
    row_d     = row_full[7:0];
  end

  always_comb begin
    raddr = row_q * 8'(GRID_COLS) + col_q;
    rdata = cells_q[AW'(raddr)];
    pix_d = COLOR_BLANK;
    if (in_grid_q && state_q == ST_RUN) begin
      if (line_q) pix_d = GRID_LINE_COLOR;
      else pix_d = value_color(rdata);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      clr_q     <= '0;
      oor_q     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      in_grid_q <= 1'b0;
      line_q    <= 1'b0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      oor_q     <= oor_d;
      col_q     <= col_d;
      row_q     <= row_d;
      in_grid_q <= in_grid_d;
      line_q    <= line_d;
      pix_q     <= pix_d;
    end
  end

  assign PIXEL_COLOR = pix_q;
  assign READY       = (state_q == ST_RUN);
  assign OOR_FLAG    = oor_q;

endmodule

// File: tb/tb_grid_map_store.sv
// Directed self-checking bench for grid_map_store: clear sweep,
// strobe writes, out-of-range flag, pixel colours and reset restart.
module tb_grid_map_store;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x, y;
  logic [1:0] v;
  logic       en;
  logic [9:0] px, py;
  logic [7:0] color;
  logic       ready;
  logic       oor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grid_map_store dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .X_COORD     (x),
    .Y_COORD     (y),
    .VALUE       (v),
    .ENABLE_IN   (en),
    .PIXEL_X     (px),
    .PIXEL_Y     (py),
    .PIXEL_COLOR (color),
    .READY       (ready),
    .OOR_FLAG    (oor)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Called right after reset release: 19 cycles not ready, ready at edge 20.
  task automatic check_sweep();
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      chk("sweep_ready_low", {7'b0, ready}, 8'h00);
      chk("sweep_color", color, 8'h00);
    end
    @(negedge clk);
    chk("sweep_ready_high", {7'b0, ready}, 8'h01);
  endtask

  task automatic pixel(input string tag, input int ix, input int iy,
                       input logic [7:0] exp);
    @(negedge clk);
    px = 10'(ix);
    py = 10'(iy);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk(tag, color, exp);
  endtask

  task automatic strobe(input logic [3:0] sx, input logic [3:0] sy,
                        input logic [1:0] sv, input int hi);
    @(negedge clk);
    x = sx;
    y = sy;
    v = sv;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (hi) @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    x   = '0;
    y   = '0;
    v   = '0;
    px  = 10'd80;
    py  = 10'd40;
    repeat (3) @(negedge clk);
    chk("rst_color", color, 8'h00);
    chk("rst_ready", {7'b0, ready}, 8'h00);
    chk("rst_oor", {7'b0, oor}, 8'h00);

    rst = 1'b0;
    check_sweep();
    pixel("clear_c7", 80, 40, 8'h00);
    pixel("clear_c0", 10, 10, 8'h00);
    pixel("clear_c19", 150, 110, 8'h00);

    // (2,1)=WALL, 10-cycle strobe; pixel (80,40) held to time the update
    @(negedge clk);
    x  = 4'd2;
    y  = 4'd1;
    v  = 2'd2;
    px = 10'd80;
    py = 10'd40;
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_latency_old", color, 8'h00);
    end
    @(negedge clk);
    chk("wr_latency_new", color, 8'hE0);
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("wr_hold_c7", color, 8'hE0);
    chk("wr_no_oor", {7'b0, oor}, 8'h00);

    strobe(4'd6, 4'd1, 2'd3, 4);
    repeat (6) @(negedge clk);
    chk("oor_set", {7'b0, oor}, 8'h01);
    pixel("oor_c7_kept", 80, 40, 8'hE0);
    pixel("oor_c11", 40, 80, 8'h00);
    pixel("oor_c6", 40, 40, 8'h00);

    pixel("line_64_40", 64, 40, 8'h92);
    pixel("col6_out", 200, 10, 8'h00);
    pixel("col31_out", 1000, 40, 8'h00);
    pixel("row6_out", 80, 200, 8'h00);
    pixel("c0_zero", 10, 10, 8'h00);
    chk("oor_sticky", {7'b0, oor}, 8'h01);

    // reset at sweep address 10 with the strobe held high throughout
    @(negedge clk);
    x  = 4'd1;
    y  = 4'd0;
    v  = 2'd3;
    en = 1'b1;
    px = 10'd80;
    py = 10'd40;
    pulse_reset();
    repeat (10) @(negedge clk);
    chk("mid_ready_low", {7'b0, ready}, 8'h00);
    pulse_reset();
    chk("mid_oor_clr", {7'b0, oor}, 8'h00);
    check_sweep();
    repeat (6) @(negedge clk);
    chk("mid_no_oor", {7'b0, oor}, 8'h00);
    pixel("mid_c1_zero", 40, 10, 8'h00);
    pixel("mid_c7_cleared", 80, 40, 8'h00);
    @(negedge clk) en = 1'b0;
    repeat (4) @(negedge clk);

    strobe(4'd0, 4'd0, 2'd1, 3);
    strobe(4'd4, 4'd3, 2'd3, 3);
    repeat (6) @(negedge clk);
    pixel("b2b_c0", 10, 10, 8'h1C);
    pixel("b2b_c19", 150, 110, 8'hFC);
    pixel("b2b_c1", 40, 10, 8'h00);
    chk("b2b_no_oor", {7'b0, oor}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
